// File: rtl/mux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
//   demux_state_e : input-side packet state (first beat vs mid-packet)
//   route_e       : destination output selector
//   BUF_DEPTH     : entries per output buffer
package mux_pkg;

  typedef enum {ST_IDLE, ST_BUSY} demux_state_e;

  typedef enum logic {ROUTE0, ROUTE1} route_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that sits in front of each demux output.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   push/push_data : write side; caller only pushes when full is low
//   full           : both entries occupied (from registered occupancy)
//   valid/ready    : read-side handshake, head entry on pop_data
//   pop            : head entry leaves this cycle (valid && ready)
// Storage resets to zero so the read data is 0 after reset. The head is read
// straight from storage, so it stays put while the consumer stalls.
module skid_fifo2
  import mux_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic         pop,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         wr_en;

  assign full     = (count == 2'(BUF_DEPTH));
  assign valid    = (count != 2'd0);
  assign pop      = valid && ready;
  assign pop_data = mem[rd_ptr];
  assign wr_en    = push && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wr_en, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_1x2.sv
// Registered 1-to-2 stream demultiplexer. Each packet is steered to out0 or
// out1 by in_sel sampled on its first beat; the route is locked until the
// last beat. Each output has its own 2-entry buffer so a stalled output does
// not disturb the other. pkt_cnt0/1 count packets fully delivered (last beat
// popped) per output and wrap.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   in_data/in_last/in_sel/in_valid   : input stream, in_ready handshake
//   outK_data/outK_last/outK_valid    : output stream K, outK_ready handshake
//   pkt_cnt0, pkt_cnt1                : delivered-packet counters
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | next accepted beat is a first beat, route = in_sel
// ST_BUSY | mid-packet, route locked to route_q
module stream_demux_1x2
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  demux_state_e state_q, state_d;
  route_e       route_q, route_d;
  route_e       route;
  logic         accept;
  logic         push0, push1;
  logic         full0, full1;
  logic         pop0, pop1;
  logic [WIDTH:0] head0, head1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      route_q <= ROUTE0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // in_ready depends only on registered occupancy and the route, never on
  // the downstream ready inputs.
  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    route    = (state_q == ST_IDLE) ? route_e'(in_sel) : route_q;
    in_ready = (route == ROUTE0) ? !full0 : !full1;
    accept   = in_valid && in_ready;
    push0    = accept && (route == ROUTE0);
    push1    = accept && (route == ROUTE1);
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_last) begin
            state_d = ST_BUSY;
            route_d = route;
          end
        end
        ST_BUSY: begin
          if (in_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  skid_fifo2 #(.W(WIDTH + 1)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data ({in_last, in_data}),
    .full      (full0),
    .valid     (out0_valid),
    .ready     (out0_ready),
    .pop       (pop0),
    .pop_data  (head0)
  );

  skid_fifo2 #(.W(WIDTH + 1)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data ({in_last, in_data}),
    .full      (full1),
    .valid     (out1_valid),
    .ready     (out1_ready),
    .pop       (pop1),
    .pop_data  (head1)
  );

  assign out0_data = head0[WIDTH-1:0];
  assign out0_last = head0[WIDTH];
  assign out1_data = head1[WIDTH-1:0];
  assign out1_last = head1[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (pop0 && out0_last) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (pop1 && out1_last) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_1x2.sv
module tb_stream_demux_1x2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_last, out1_last;
  logic             out0_valid, out1_valid;
  logic             out0_ready = 1'b1;
  logic             out1_ready = 1'b1;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  stream_demux_1x2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // scoreboard: expected {last, data} per output
  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];
  logic [WIDTH:0] e0, e1;

  // bench's own route-lock model
  logic m_busy = 1'b0;
  logic m_route = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one beat; returns the number of extra cycles waited for in_ready.
  task automatic send(input logic [WIDTH-1:0] d, input logic l, input logic s,
                      output int waited);
    logic r;
    waited   = 0;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      r = m_busy ? m_route : s;
      if (!m_busy && !l) begin
        m_busy  = 1'b1;
        m_route = s;
      end else if (m_busy && l) begin
        m_busy = 1'b0;
      end
      if (r) q1.push_back({l, d});
      else   q0.push_back({l, d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("out0_unexpected", {31'd0, out0_valid}, 32'd0);
        else begin
          e0 = q0.pop_front();
          check("out0_beat", {23'd0, out0_last, out0_data}, {23'd0, e0});
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1_unexpected", {31'd0, out1_valid}, 32'd0);
        else begin
          e1 = q1.pop_front();
          check("out1_beat", {23'd0, out1_last, out1_data}, {23'd0, e1});
        end
      end
    end
  end

  initial begin
    int w;

    // reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_out0_data", {23'd0, out0_last, out0_data}, 32'd0);
    check("rst_out1_data", {23'd0, out1_last, out1_data}, 32'd0);
    check("rst_cnt", {24'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single-beat packets, one cycle latency
    send(8'h11, 1'b1, 1'b0, w);
    check("sb_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("sb_out0_head", {23'd0, out0_last, out0_data}, 32'h111);
    send(8'h22, 1'b1, 1'b1, w);
    check("sb_out1_valid", {31'd0, out1_valid}, 32'd1);
    check("sb_out1_head", {23'd0, out1_last, out1_data}, 32'h122);
    repeat (3) @(posedge clk);
    #1;
    check("sb_cnt0", {28'd0, pkt_cnt0}, 32'd1);
    check("sb_cnt1", {28'd0, pkt_cnt1}, 32'd1);

    // route lock with in_sel toggling, back-to-back beats
    send(8'hA0, 1'b0, 1'b1, w);
    check("lock_tput0", w, 0);
    send(8'hA1, 1'b0, 1'b0, w);
    check("lock_tput1", w, 0);
    check("lock_out0_idle", {31'd0, out0_valid}, 32'd0);
    send(8'hA2, 1'b1, 1'b1, w);
    check("lock_out0_idle2", {31'd0, out0_valid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("lock_cnt1", {28'd0, pkt_cnt1}, 32'd2);
    check("lock_cnt0", {28'd0, pkt_cnt0}, 32'd1);

    // backpressure: 4-beat packet to a stalled out0
    out0_ready = 1'b0;
    send(8'hB0, 1'b0, 1'b0, w);
    send(8'hB1, 1'b0, 1'b0, w);
    in_data  = 8'hB2;
    in_last  = 1'b0;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("bp_full_ready2", {31'd0, in_ready}, 32'd0);
    check("bp_hold_head", {23'd0, out0_last, out0_data}, 32'h0B0);
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", {31'd0, in_ready}, 32'd0);
    send(8'hB2, 1'b0, 1'b0, w);
    check("bp_resume", w, 0);
    send(8'hB3, 1'b1, 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    check("bp_cnt0", {28'd0, pkt_cnt0}, 32'd2);

    // isolation: out0 stalled and full, out1 still served
    out0_ready = 1'b0;
    send(8'hC0, 1'b1, 1'b0, w);
    send(8'hC1, 1'b1, 1'b0, w);
    send(8'hD0, 1'b1, 1'b1, w);
    check("iso_accept", w, 0);
    check("iso_out1_head", {23'd0, out1_last, out1_data}, 32'h1D0);
    check("iso_out0_hold", {22'd0, out0_valid, out0_last, out0_data}, 32'h3C0);
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("iso_cnt0", {28'd0, pkt_cnt0}, 32'd4);
    check("iso_cnt1", {28'd0, pkt_cnt1}, 32'd3);

    // async reset mid-packet
    out1_ready = 1'b0;
    send(8'hE0, 1'b0, 1'b1, w);
    send(8'hE1, 1'b0, 1'b1, w);
    in_data  = 8'hE2;
    in_last  = 1'b0;
    in_sel   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("arst_out1_data", {23'd0, out1_last, out1_data}, 32'd0);
    check("arst_cnt", {24'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    q0.delete();
    q1.delete();
    m_busy   = 1'b0;
    m_route  = 1'b0;
    in_valid = 1'b0;
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hF0, 1'b1, 1'b0, w);
    check("arst_new_route", {22'd0, out0_valid, out0_last, out0_data}, 32'h3F0);
    check("arst_out1_quiet", {31'd0, out1_valid}, 32'd0);

    // counter wrap: 17 packets to out1 with CNT_W=4
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i), 1'b1, 1'b1, w);
    repeat (4) @(posedge clk);
    #1;
    check("wrap_cnt1", {28'd0, pkt_cnt1}, 32'd1);
    check("wrap_cnt0", {28'd0, pkt_cnt0}, 32'd1);
    check("sb_q0_drained", q0.size(), 0);
    check("sb_q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
